// File: rtl/digdug_wsg_mixer_if.sv
// Bus bundle for the waveform sound generator: register writes from the
// I/O device, the wave ROM address/data pair and the PCM sample output.
interface digdug_wsg_mixer_if #(
    parameter int ACC_W = 20,
    parameter int OUT_W = 8
);
    logic             WR;
    logic [2:0]       WVOICE;
    logic [1:0]       WFLD;
    logic [ACC_W-1:0] WDATA;
    logic [7:0]       WAVEAD;
    logic [3:0]       WAVEDT;
    logic [OUT_W-1:0] SOUT;
    logic             SSTB;

    // Register writer / wave ROM side
    modport master (
        output WR, WVOICE, WFLD, WDATA, WAVEDT,
        input  WAVEAD, SOUT, SSTB
    );

    // Sound generator side
    modport slave (
        input  WR, WVOICE, WFLD, WDATA, WAVEDT,
        output WAVEAD, SOUT, SSTB
    );
endinterface

// File: rtl/digdug_wsg_mixer.sv
// Namco-style waveform sound generator. Once per output sample the voices are
// scanned in turn: phase step, wave ROM fetch, volume scaling and summing,
// followed by one saturated PCM sample with a strobe.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | wait for the sample divider tick
// ADDR   | present {wave, phase} of voice v to the ROM, advance its phase
// DATA   | ROM latency cycle, address held
// MAC    | add ROM data * volume of voice v into the sum
// DONE   | saturate the sum into SOUT and pulse SSTB
module digdug_wsg_mixer #(
    parameter int VOICES     = 3,
    parameter int ACC_W      = 20,
    parameter int SAMPLE_DIV = 500,
    parameter int OUT_W      = 8,
    parameter int MIX_SHIFT  = 1
) (
    input  logic              MCLK,
    input  logic              RESET,
    digdug_wsg_mixer_if.slave bus
);

    localparam int SUM_W = 8 + $clog2(VOICES);
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam logic [31:0] OUT_MAX = 32'((64'd1 << OUT_W) - 64'd1);

    if (SAMPLE_DIV < 3 * VOICES + 2 || VOICES < 1 || VOICES > 8) begin : g_param_check
        $error("digdug_wsg_mixer: VOICES must be 1..8 and SAMPLE_DIV >= 3*VOICES+2");
    end

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_MAC, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q;
    logic               tick;
    logic [2:0]         v_q;
    logic [SUM_W-1:0]   sum_q;
    logic [SUM_W-1:0]   sum_shift;
    logic               sat_over;
    logic [7:0]         wavead_q;
    logic [OUT_W-1:0]   sout_q;
    logic               sstb_q;
    logic [7:0]         prod;

    logic [ACC_W-1:0]   acc  [VOICES];
    logic [ACC_W-1:0]   freq [VOICES];
    logic [2:0]         wave [VOICES];
    logic [3:0]         vol  [VOICES];

    logic [2:0]         cur_wave;
    logic [4:0]         cur_phase;
    logic [3:0]         cur_vol;

    assign tick      = (div_q == DIV_W'(SAMPLE_DIV - 1));
    assign prod      = {4'd0, bus.WAVEDT} * {4'd0, cur_vol};
    assign sum_shift = sum_q >> MIX_SHIFT;
    assign sat_over  = 32'(sum_shift) > OUT_MAX;

    // The address is combinational in ADDR so a write landing the cycle before
    // is already seen; the register keeps it stable through DATA and beyond.
    assign bus.WAVEAD = (state_q == S_ADDR) ? {cur_wave, cur_phase} : wavead_q;
    assign bus.SOUT   = sout_q;
    assign bus.SSTB   = sstb_q;

    // Select the per-voice registers of the voice being scanned
    always_comb begin
        cur_wave  = '0;
        cur_phase = '0;
        cur_vol   = '0;
        for (int i = 0; i < VOICES; i++) begin
            if (v_q == 3'(i)) begin
                cur_wave  = wave[i];
                cur_phase = acc[i][ACC_W-1 -: 5];
                cur_vol   = vol[i];
            end
        end
    end

    // Sample-rate divider, free running 0..SAMPLE_DIV-1
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) div_q <= '0;
        else       div_q <= tick ? '0 : div_q + DIV_W'(1);
    end

    // Per-voice register file and phase accumulators; out-of-range voices and
    // the reserved field never match, so those writes fall away
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < VOICES; i++) begin
                acc[i]  <= '0;
                freq[i] <= '0;
                wave[i] <= '0;
                vol[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < VOICES; i++) begin
                if (bus.WR && bus.WVOICE == 3'(i)) begin
                    case (bus.WFLD)
                        2'd0:    freq[i] <= bus.WDATA;
                        2'd1:    wave[i] <= bus.WDATA[2:0];
                        2'd2:    vol[i]  <= bus.WDATA[3:0];
                        default: ;
                    endcase
                end
                if (state_q == S_ADDR && v_q == 3'(i))
                    acc[i] <= acc[i] + freq[i];
            end
        end
    end

    // FSM state register
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (tick) state_d = S_ADDR;
            S_ADDR:  state_d = S_DATA;
            S_DATA:  state_d = S_MAC;
            S_MAC:   state_d = (v_q == 3'(VOICES - 1)) ? S_DONE : S_ADDR;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Scan datapath: voice index, accumulation, address hold and output sample
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            v_q      <= '0;
            sum_q    <= '0;
            wavead_q <= '0;
            sout_q   <= '0;
            sstb_q   <= 1'b0;
        end else begin
            sstb_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (tick) begin
                        sum_q <= '0;
                        v_q   <= '0;
                    end
                end
                S_ADDR: wavead_q <= {cur_wave, cur_phase};
                S_MAC: begin
                    sum_q <= sum_q + SUM_W'(prod);
                    v_q   <= v_q + 3'd1;
                end
                S_DONE: begin
                    sout_q <= sat_over ? OUT_W'(OUT_MAX) : OUT_W'(sum_shift);
                    sstb_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_digdug_wsg_mixer.sv
// Directed bench for digdug_wsg_mixer with VOICES=3, SAMPLE_DIV=500.
// Tick cycle T is derived from a strobe S: S = T+11, next tick at S+489,
// voice v ADDR at tick+1+3v.
module tb_digdug_wsg_mixer;

    logic MCLK  = 1'b0;
    logic RESET = 1'b1;
    logic [3:0] rom_const = 4'hF;
    int checks = 0;
    int fails  = 0;

    digdug_wsg_mixer_if #(.ACC_W(20), .OUT_W(8)) bus ();

    digdug_wsg_mixer #(
        .VOICES(3), .ACC_W(20), .SAMPLE_DIV(500), .OUT_W(8), .MIX_SHIFT(1)
    ) dut (
        .MCLK  (MCLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 MCLK = ~MCLK;

    // Synchronous wave ROM returning one constant value
    always @(posedge MCLK) bus.WAVEDT <= rom_const;

    // One register write; called at a negedge, returns one negedge later
    task automatic write_reg(input logic [2:0] v, input logic [1:0] f, input logic [19:0] d);
        bus.WR = 1'b1; bus.WVOICE = v; bus.WFLD = f; bus.WDATA = d;
        @(negedge MCLK);
        bus.WR = 1'b0;
    endtask

    // Advance negedge by negedge until SSTB is seen or the limit runs out
    task automatic wait_strobe(input int limit, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        while (n < limit && !ok) begin
            @(negedge MCLK);
            n++;
            if (bus.SSTB === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        bit ok; int n;
        RESET = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.WR = 1'($urandom); bus.WVOICE = 3'($urandom); bus.WFLD = 2'($urandom);
            bus.WDATA = 20'($urandom);
            @(negedge MCLK);
        end
        bus.WR = 1'b0;
        checks++; if (bus.SOUT !== 8'd0) begin fails++; $display("FAIL reset_sout got %0d want 0", bus.SOUT); end
        checks++; if (bus.SSTB !== 1'b0) begin fails++; $display("FAIL reset_sstb got %b want 0", bus.SSTB); end
        checks++; if (bus.WAVEAD !== 8'h00) begin fails++; $display("FAIL reset_wavead got %h want 00", bus.WAVEAD); end
        RESET = 1'b0;
        // release cycle counts as cycle 1: first strobe in cycle 511 = 510 negedges on
        wait_strobe(700, ok, n);
        checks++; if (!ok || n != 510) begin fails++; $display("FAIL reset_first_sstb got %0d want 510 (ok=%0d)", n, ok); end
        checks++; if (bus.SOUT !== 8'd0) begin fails++; $display("FAIL reset_first_sout got %0d want 0", bus.SOUT); end
    endtask

    task automatic test_single_voice;
        bit ok; int n;
        write_reg(3'd0, 2'd1, 20'd1);
        write_reg(3'd0, 2'd2, 20'd15);
        wait_strobe(700, ok, n);
        checks++; if (!ok || bus.SOUT !== 8'd112) begin fails++; $display("FAIL single_sout1 got %0d want 112", bus.SOUT); end
        wait_strobe(700, ok, n);
        checks++; if (!ok || n != 500) begin fails++; $display("FAIL single_period got %0d want 500", n); end
        checks++; if (bus.SOUT !== 8'd112) begin fails++; $display("FAIL single_sout2 got %0d want 112", bus.SOUT); end
        @(negedge MCLK);
        checks++; if (bus.SSTB !== 1'b0) begin fails++; $display("FAIL single_sstb_width got %b want 0", bus.SSTB); end
        repeat (489) @(negedge MCLK);
        checks++; if (bus.WAVEAD !== 8'h20) begin fails++; $display("FAIL single_wavead got %h want 20", bus.WAVEAD); end
        wait_strobe(700, ok, n);
        checks++; if (!ok || n != 10) begin fails++; $display("FAIL single_latency got %0d want 10", n); end
        checks++; if (bus.SOUT !== 8'd112) begin fails++; $display("FAIL single_sout3 got %0d want 112", bus.SOUT); end
    endtask

    task automatic test_saturation;
        bit ok; int n;
        write_reg(3'd1, 2'd2, 20'd15);
        write_reg(3'd2, 2'd2, 20'd15);
        wait_strobe(700, ok, n);
        checks++; if (!ok || bus.SOUT !== 8'd255) begin fails++; $display("FAIL sat_three got %0d want 255", bus.SOUT); end
        write_reg(3'd2, 2'd2, 20'd0);
        wait_strobe(700, ok, n);
        checks++; if (!ok || bus.SOUT !== 8'd225) begin fails++; $display("FAIL sat_two got %0d want 225", bus.SOUT); end
        // rom 5: 5*3 + 5*15 = 90, >>1 = 45
        write_reg(3'd0, 2'd2, 20'd3);
        rom_const = 4'd5;
        wait_strobe(700, ok, n);
        checks++; if (!ok || bus.SOUT !== 8'd45) begin fails++; $display("FAIL mix_scaled got %0d want 45", bus.SOUT); end
        rom_const = 4'hF;
    endtask

    task automatic test_phase_step;
        bit ok; int n;
        logic [7:0] exp;
        write_reg(3'd0, 2'd1, 20'd0);
        write_reg(3'd0, 2'd0, 20'd32768);
        for (int i = 0; i < 33; i++) begin
            if (i == 0) repeat (488) @(negedge MCLK);
            else begin
                wait_strobe(700, ok, n);
                checks++; if (!ok) begin fails++; $display("FAIL phase_strobe got none want strobe at step %0d", i); end
                repeat (490) @(negedge MCLK);
            end
            exp = 8'(i % 32);
            checks++; if (bus.WAVEAD !== exp) begin fails++; $display("FAIL phase_step%0d got %h want %h", i, bus.WAVEAD, exp); end
        end
        wait_strobe(700, ok, n);
        write_reg(3'd0, 2'd0, 20'd0);
        repeat (489) @(negedge MCLK);
        checks++; if (bus.WAVEAD !== 8'h01) begin fails++; $display("FAIL phase_hold1 got %h want 01", bus.WAVEAD); end
        wait_strobe(700, ok, n);
        repeat (490) @(negedge MCLK);
        checks++; if (bus.WAVEAD !== 8'h01) begin fails++; $display("FAIL phase_hold2 got %h want 01", bus.WAVEAD); end
    endtask

    task automatic test_ignored_writes;
        bit ok; int n;
        wait_strobe(700, ok, n);
        write_reg(3'd0, 2'd2, 20'd0);
        write_reg(3'd1, 2'd2, 20'd0);
        write_reg(3'd2, 2'd2, 20'd0);
        write_reg(3'd3, 2'd2, 20'd15);
        write_reg(3'd7, 2'd2, 20'd15);
        write_reg(3'd0, 2'd3, 20'hFFFFF);
        write_reg(3'd1, 2'd3, 20'hFFFFF);
        wait_strobe(700, ok, n);
        checks++; if (!ok || bus.SOUT !== 8'd0) begin fails++; $display("FAIL ignored_sout1 got %0d want 0", bus.SOUT); end
        wait_strobe(700, ok, n);
        checks++; if (!ok || bus.SOUT !== 8'd0) begin fails++; $display("FAIL ignored_sout2 got %0d want 0", bus.SOUT); end
    endtask

    task automatic test_mid_scan_reset;
        bit ok; int n;
        write_reg(3'd0, 2'd2, 20'd15);
        write_reg(3'd1, 2'd1, 20'd3);
        wait_strobe(700, ok, n);
        checks++; if (!ok || bus.SOUT !== 8'd112) begin fails++; $display("FAIL midrst_pre_sout got %0d want 112", bus.SOUT); end
        repeat (489 + 5) @(negedge MCLK);
        checks++; if (bus.WAVEAD !== 8'h60) begin fails++; $display("FAIL midrst_pre_wavead got %h want 60", bus.WAVEAD); end
        RESET = 1'b1;
        #1;
        checks++; if (bus.SOUT !== 8'd0) begin fails++; $display("FAIL midrst_sout got %0d want 0", bus.SOUT); end
        checks++; if (bus.WAVEAD !== 8'h00) begin fails++; $display("FAIL midrst_wavead got %h want 00", bus.WAVEAD); end
        checks++; if (bus.SSTB !== 1'b0) begin fails++; $display("FAIL midrst_sstb got %b want 0", bus.SSTB); end
        repeat (2) @(negedge MCLK);
        RESET = 1'b0;
        wait_strobe(700, ok, n);
        checks++; if (!ok || n != 510) begin fails++; $display("FAIL midrst_next_sstb got %0d want 510", n); end
        checks++; if (bus.SOUT !== 8'd0) begin fails++; $display("FAIL midrst_regs_cleared got %0d want 0", bus.SOUT); end
    endtask

    task automatic test_collision;
        bit ok; int n;
        repeat (489 + 6) @(negedge MCLK);
        bus.WR = 1'b1; bus.WVOICE = 3'd1; bus.WFLD = 2'd2; bus.WDATA = 20'd15;
        @(negedge MCLK);
        bus.WR = 1'b0;
        wait_strobe(700, ok, n);
        checks++; if (!ok || n != 4) begin fails++; $display("FAIL collide_timing got %0d want 4", n); end
        checks++; if (bus.SOUT !== 8'd0) begin fails++; $display("FAIL collide_old_vol got %0d want 0", bus.SOUT); end
        wait_strobe(700, ok, n);
        checks++; if (!ok || bus.SOUT !== 8'd112) begin fails++; $display("FAIL collide_new_vol got %0d want 112", bus.SOUT); end
    endtask

    initial begin
        bus.WR = 1'b0; bus.WVOICE = '0; bus.WFLD = '0; bus.WDATA = '0;
        @(negedge MCLK);
        test_reset();
        test_single_voice();
        test_saturation();
        test_phase_step();
        test_ignored_writes();
        test_mid_scan_reset();
        test_collision();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule

// File: doc/digdug_wsg_mixer.md
# digdug_wsg_mixer

Parametrised Namco-style waveform sound generator that replaces the fixed three-voice sound path feeding `SOUT`. Every output sample it scans all voices in time-multiplexed order, adds each voice's frequency to its phase accumulator and fetches a 4-bit sample from the external wave ROM. It then scales the sample by the voice volume, accumulates, and emits one saturated PCM sample with a strobe. The block sits between the I/O device register writes and the top-level sound output, on the 48 MHz master clock.

## Interface
- `VOICES`, default 3: number of voices, 1..8.
- `ACC_W`, default 20: phase accumulator and frequency width.
- `SAMPLE_DIV`, default 500: MCLK cycles per output sample (96 kHz at 48 MHz). Must be ≥ 3·VOICES+2; violation is an elaboration error.
- `OUT_W`, default 8: PCM output width.
- `MIX_SHIFT`, default 1: right shift applied to the voice sum before saturation.

- `MCLK` in 1: master clock, 48 MHz.
- `RESET` in 1: asynchronous, active-high reset.
- `WR` in 1: register write strobe, one cycle.
- `WVOICE` in 3: target voice index.
- `WFLD` in 2: field select. 0 = frequency, 1 = waveform, 2 = volume, 3 = reserved.
- `WDATA` in ACC_W: write data. Waveform uses `[2:0]`; volume uses `[3:0]`.
- `WAVEAD` out 8: wave ROM address, {waveform[2:0], phase[4:0]}.
- `WAVEDT` in 4: wave ROM data, synchronous ROM on MCLK with 1-cycle latency.
- `SOUT` out OUT_W: registered PCM sample.
- `SSTB` out 1: one-cycle pulse on the cycle `SOUT` updates.

## Operation
- **Reset values.** All outputs are 0. Divider, all phase accumulators, frequency, waveform and volume registers are 0. The FSM is in IDLE.
- **Register file.** On `WR`, the field `WFLD` of voice `WVOICE` is loaded from `WDATA`. The write is ignored when `WVOICE ≥ VOICES` or `WFLD = 3`. A written value is visible to the sequencer from the next cycle.
- **Divider.** Counts 0..SAMPLE_DIV-1 and wraps. `tick` is asserted when the count equals SAMPLE_DIV-1.
- **FSM: IDLE → ADDR → DATA → MAC → (ADDR of next voice | DONE) → IDLE.**
  - IDLE: waits for `tick`, then clears `sum`, sets voice v = 0 and moves to ADDR.
  - ADDR: drives `WAVEAD = {wave[v], acc[v][ACC_W-1:ACC_W-5]}` using the pre-increment phase. In the same cycle, `acc[v] <= acc[v] + freq[v]` modulo 2^ACC_W.
  - DATA: waits for the ROM latency. `WAVEAD` holds its value.
  - MAC: `sum <= sum + WAVEDT·vol[v]`, with volume sampled this cycle. Goes to ADDR with v+1, or to DONE after v = VOICES-1.
  - DONE: `SOUT <= min(sum >> MIX_SHIFT, 2^OUT_W - 1)`, `SSTB <= 1`, then returns to IDLE.
- **Widths.** The product is 8 bits unsigned. `sum` is 8+clog2(VOICES) bits and never overflows.
- **Boundary behaviour.**
  - freq = 0: the phase holds.
  - vol = 0: the voice contributes 0.
  - Phase wraps silently from 31 to 0.
  - A write to a voice whose ADDR/MAC cycle is the same cycle uses the old value.
  - `tick` cannot occur while a scan is in progress, because of the SAMPLE_DIV constraint.
- **Reset mid-scan.** Asynchronously forces every register to its reset value. The partial sum is discarded and no strobe is issued.

## Timing
- `tick` is on cycle T. ADDR for voice v occurs at T+1+3v, DATA at T+2+3v, MAC at T+3+3v. DONE is at T+1+3·VOICES.
- `SOUT`/`SSTB` become visible the cycle after DONE: latency from `tick` is 3·VOICES+2 cycles, which is 11 for VOICES = 3.
- `SSTB` is high for exactly one cycle. Strobe period is exactly SAMPLE_DIV cycles.
- After `RESET` deasserts, the first `tick` occurs SAMPLE_DIV cycles later.
- `WAVEAD` holds its last value outside ADDR/DATA.

## Test plan
- **Reset.** Drive `RESET` for 5 cycles with random inputs → `SOUT = 0`, `SSTB = 0`, `WAVEAD = 0`. The first `SSTB` appears SAMPLE_DIV+11 cycles after release.
- **Single voice.** Voice 0: wave 1, vol 15, freq 0; ROM returns 4'hF → every strobe gives `SOUT = 112` (225>>1) and `WAVEAD = 8'h20` during voice 0's ADDR. Strobes are spaced exactly 500 cycles apart.
- **Saturation.** All 3 voices at vol 15 with ROM data 15 → sum 675, 675>>1 = 337 → `SOUT = 255`. With only voices 0 and 1 active → `SOUT = 225`.
- **Phase stepping.** Voice 0: freq = 32768 (2^15), wave 0 → phase bits of voice 0's `WAVEAD` step 0,1,…,31,0 over 33 consecutive samples.
- **Ignored writes.** Write `WVOICE = 3` (and `WVOICE = 7`) with vol 15, then `WFLD = 3` with any data → `SOUT` stays 0 when all valid voices are at vol 0.
- **Mid-scan reset and collision.**
  - Assert `RESET` at T+5 → outputs go to 0 immediately and no `SSTB` follows.
  - Separately, write vol 15 to voice 1 on its MAC cycle T+6 → that sample uses the old volume 0, and the next sample uses 15.
